// File: rtl/angle_interp_pkg.sv
// Shared types and constants for the wheel angle interpolator.
package angle_interp_pkg;

    // Tracking state: waiting for a zero, waiting for the first full slot, tracking.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } state_e;

    localparam int STEP_W  = 16;
    localparam int SUB_W   = 32;
    localparam int SPEED_W = 32;

    localparam int DEF_TEETH      = 120;
    localparam int DEF_SUB_DIV    = 16;
    localparam int DEF_MAX_PERIOD = 2000000;

endpackage

// File: rtl/angle_interp_if.sv
// Edge/zero inputs and angle outputs between motor_top, the interpolator and its consumers.
interface angle_interp_if;

    logic                                   motor_enable;
    logic                                   wheel_edge;
    logic                                   real_zero_flag;
    logic [angle_interp_pkg::STEP_W-1:0]    step_cnt;
    logic [angle_interp_pkg::SUB_W-1:0]     sub_cnt;
    logic [angle_interp_pkg::SPEED_W-1:0]   speed_cnt;
    logic                                   angle_valid;
    logic                                   sync_err;

    modport master (
        output motor_enable, wheel_edge, real_zero_flag,
        input  step_cnt, sub_cnt, speed_cnt, angle_valid, sync_err
    );

    modport slave (
        input  motor_enable, wheel_edge, real_zero_flag,
        output step_cnt, sub_cnt, speed_cnt, angle_valid, sync_err
    );

endinterface

// File: rtl/angle_interp_subdiv.sv
// Divider-free sub-slot extrapolation: adds SUB_DIV per cycle and emits a tick
// each time the running sum crosses the previous slot period P.
module angle_subdiv
    import angle_interp_pkg::*;
#(
    parameter int SUB_DIV = DEF_SUB_DIV
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic [SPEED_W-1:0] period_i,
    output logic [SUB_W-1:0]   sub_cnt_o,
    output logic               tick_o
);

    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_DIV - 1);

    logic [32:0]      acc_q, acc_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [33:0]      acc_inc;
    logic [33:0]      period_ext;

    // Accumulator step; clear wins over a tick landing in the same cycle.
    always_comb begin
        acc_inc    = {1'b0, acc_q} + 34'(SUB_DIV);
        period_ext = {2'b00, period_i};
        acc_d      = acc_q;
        sub_d      = sub_q;
        tick_o     = 1'b0;
        if (clear_i) begin
            acc_d = '0;
            sub_d = '0;
        end else if (enable_i) begin
            if (acc_inc >= period_ext) begin
                acc_d = 33'(acc_inc - period_ext);
                // A slowing wheel parks at the last sub-step until the next edge.
                if (sub_q != SUB_MAX) begin
                    sub_d  = sub_q + SUB_W'(1);
                    tick_o = 1'b1;
                end
            end else begin
                acc_d = 33'(acc_inc);
            end
        end
    end

    // Accumulator and sub-step registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sub_q <= '0;
        end else begin
            acc_q <= acc_d;
            sub_q <= sub_d;
        end
    end

    assign sub_cnt_o = sub_q;

endmodule

// File: rtl/angle_interp.sv
// Absolute wheel angle tracker: slot index from wheel edges, sub-slot position
// extrapolated from the last slot period, zero/stall supervision.
module angle_interp
    import angle_interp_pkg::*;
#(
    parameter int TEETH      = DEF_TEETH,
    parameter int SUB_DIV    = DEF_SUB_DIV,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD
) (
    input  logic          clk,
    input  logic          rst,
    angle_interp_if.slave bus
);

    localparam logic [SPEED_W-1:0] PMAX      = SPEED_W'(MAX_PERIOD);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(TEETH - 1);

    state_e             state_q, state_d;
    logic [SPEED_W-1:0] period_q, period_d;
    logic [SPEED_W-1:0] p_q, p_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               valid_q, valid_d;
    logic               serr_q, serr_d;

    logic               sub_clr;
    logic               sub_en;
    logic               sub_tick;
    logic               stall;
    logic               edge_ok;

    // Cycles since the last wheel edge; restarts at 1 on an edge, saturates at the stall limit.
    always_comb begin
        period_d = period_q;
        if (bus.wheel_edge)
            period_d = SPEED_W'(1);
        else if (period_q != PMAX)
            period_d = period_q + SPEED_W'(1);
    end

    assign stall = (period_q == PMAX) && !bus.wheel_edge;

    // Sub ticks only run while tracking, and an edge in the same cycle suppresses them.
    assign sub_en = (state_q == TRACK) && bus.motor_enable && !bus.wheel_edge;

    // Next-state, slot index and strobe logic.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        p_d     = p_q;
        speed_d = speed_q;
        valid_d = 1'b0;
        serr_d  = 1'b0;
        sub_clr = 1'b0;
        edge_ok = 1'b0;
        if (!bus.motor_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.wheel_edge && bus.real_zero_flag) begin
                        state_d = SYNC;
                        step_d  = '0;
                        sub_clr = 1'b1;
                    end
                end
                SYNC: begin
                    if (bus.wheel_edge) begin
                        edge_ok = 1'b1;
                        state_d = TRACK;
                        if (bus.real_zero_flag) begin
                            step_d = '0;
                            serr_d = (STEP_LAST != '0);
                        end else begin
                            step_d = STEP_W'(1);
                        end
                    end else if (stall) begin
                        serr_d  = 1'b1;
                        speed_d = PMAX;
                        state_d = IDLE;
                    end
                end
                TRACK: begin
                    if (bus.wheel_edge) begin
                        if (bus.real_zero_flag) begin
                            // Zero seen: resync, complain only if it is not where we expected.
                            edge_ok = 1'b1;
                            step_d  = '0;
                            serr_d  = (step_q != STEP_LAST);
                        end else if (step_q == STEP_LAST) begin
                            // Zero missing after the last slot: drop tracking, hold outputs.
                            serr_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            edge_ok = 1'b1;
                            step_d  = step_q + STEP_W'(1);
                        end
                    end else if (stall) begin
                        serr_d  = 1'b1;
                        speed_d = PMAX;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (edge_ok) begin
            p_d     = period_q;
            speed_d = period_q;
            sub_clr = 1'b1;
            valid_d = 1'b1;
        end
        if (sub_tick)
            valid_d = 1'b1;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            p_q      <= '0;
            speed_q  <= '0;
            step_q   <= '0;
            valid_q  <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            p_q      <= p_d;
            speed_q  <= speed_d;
            step_q   <= step_d;
            valid_q  <= valid_d;
            serr_q   <= serr_d;
        end
    end

    angle_subdiv #(
        .SUB_DIV (SUB_DIV)
    ) u_subdiv (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (sub_clr),
        .enable_i  (sub_en),
        .period_i  (p_q),
        .sub_cnt_o (bus.sub_cnt),
        .tick_o    (sub_tick)
    );

    assign bus.step_cnt    = step_q;
    assign bus.speed_cnt   = speed_q;
    assign bus.angle_valid = valid_q;
    assign bus.sync_err    = serr_q;

endmodule

// File: tb/tb_angle_interp.sv
// Scoreboard bench for angle_interp: each driven edge queues the angle_valid
// events and sync_err pulses it should cause; a monitor pops them as they occur.
module tb_angle_interp;
    import angle_interp_pkg::*;

    localparam int TEETH      = 8;
    localparam int SUB_DIV    = 4;
    localparam int MAX_PERIOD = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    angle_interp_if bus();

    angle_interp #(
        .TEETH      (TEETH),
        .SUB_DIV    (SUB_DIV),
        .MAX_PERIOD (MAX_PERIOD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int step;
        int sub;
    } ev_t;

    ev_t exp_q[$];
    int  err_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    // Bench-side view of tracking: 0 idle, 1 sync, 2 track.
    int  st        = 0;
    int  mstep     = 0;
    int  last_e    = 0;
    int  exp_speed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: compare every strobe against the queued expectation.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            chk("av_missing", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        while (err_q.size() > 0 && err_q[0] < cyc) begin
            chk("serr_missing", cyc, err_q[0]);
            void'(err_q.pop_front());
        end
        if (bus.angle_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("av_unexpected", bus.angle_valid, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("av_cyc", cyc, e.cyc);
                chk("av_step", bus.step_cnt, e.step);
                chk("av_sub", bus.sub_cnt, e.sub);
            end
        end
        if (bus.sync_err === 1'b1) begin
            if (err_q.size() == 0)
                chk("serr_unexpected", bus.sync_err, 0);
            else
                chk("serr_cyc", cyc, err_q.pop_front());
        end
    end

    // One wheel edge followed by a slot of len cycles (len >= 2).
    task automatic do_edge(input bit zero, input int len);
        int  e;
        int  p;
        bit  acc_ok;
        @(posedge clk);
        #1;
        e      = cyc + 1;
        p      = e - last_e;
        if (p > MAX_PERIOD) p = MAX_PERIOD;
        last_e = e;
        acc_ok = 1'b0;
        bus.wheel_edge     = 1'b1;
        bus.real_zero_flag = zero;
        case (st)
            0: begin
                if (zero) begin
                    st    = 1;
                    mstep = 0;
                end
            end
            1: begin
                st     = 2;
                mstep  = zero ? 0 : 1;
                if (zero) err_q.push_back(e);
                acc_ok = 1'b1;
            end
            default: begin
                if (zero) begin
                    if (mstep != TEETH - 1) err_q.push_back(e);
                    mstep  = 0;
                    acc_ok = 1'b1;
                end else if (mstep == TEETH - 1) begin
                    err_q.push_back(e);
                    st = 0;
                end else begin
                    mstep++;
                    acc_ok = 1'b1;
                end
            end
        endcase
        if (acc_ok) begin
            exp_speed = p;
            exp_q.push_back(ev_t'{cyc: e, step: mstep, sub: 0});
            // Tick t lands ceil(t*P/SUB_DIV) cycles after the edge.
            for (int t = 1; t < SUB_DIV; t++) begin
                int tc;
                tc = e + (t * p + SUB_DIV - 1) / SUB_DIV;
                if (tc < e + len && tc <= e + MAX_PERIOD)
                    exp_q.push_back(ev_t'{cyc: tc, step: mstep, sub: t});
            end
        end
        if (st != 0 && len > MAX_PERIOD) begin
            err_q.push_back(e + MAX_PERIOD);
            exp_speed = MAX_PERIOD;
            st = 0;
        end
        @(posedge clk);
        #1;
        bus.wheel_edge     = 1'b0;
        bus.real_zero_flag = 1'b0;
        repeat (len - 2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.motor_enable   = 1'b1;
        bus.wheel_edge     = 1'b0;
        bus.real_zero_flag = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_step", bus.step_cnt, 0);
        chk("rst_sub", bus.sub_cnt, 0);
        chk("rst_speed", bus.speed_cnt, 0);
        chk("rst_valid", bus.angle_valid, 0);
        chk("rst_serr", bus.sync_err, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Edges with no zero are ignored.
        do_edge(0, 100);
        do_edge(0, 100);
        chk("pre_step", bus.step_cnt, 0);
        chk("pre_speed", bus.speed_cnt, 0);

        // Zero, then a full revolution wrapping back to slot 0.
        do_edge(1, 100);
        for (int i = 0; i < TEETH - 1; i++) do_edge(0, 100);
        do_edge(1, 100);
        chk("speed_track", bus.speed_cnt, exp_speed);
        chk("speed_100", bus.speed_cnt, 100);

        // Misplaced zero at step 3.
        for (int i = 0; i < 3; i++) do_edge(0, 100);
        chk("step_3", bus.step_cnt, 3);
        do_edge(1, 100);

        // Slow slot: sub parks at SUB_DIV-1, then P=300 paces ticks at 75.
        do_edge(0, 300);
        chk("sub_hold", bus.sub_cnt, SUB_DIV - 1);
        do_edge(0, 300);
        chk("speed_slow", bus.speed_cnt, 300);

        // Run to the last slot, then miss the zero.
        for (int i = 0; i < 5; i++) do_edge(0, 100);
        do_edge(0, 100);
        chk("step_hold", bus.step_cnt, TEETH - 1);
        do_edge(0, 100);

        // Stall: no edge for MAX_PERIOD cycles while tracking.
        do_edge(1, 100);
        do_edge(0, 600);
        chk("speed_stall", bus.speed_cnt, MAX_PERIOD);

        // Reset in the middle of slot 5.
        do_edge(1, 100);
        for (int i = 0; i < 4; i++) do_edge(0, 100);
        do_edge(0, 40);
        chk("pre_rst_step", bus.step_cnt, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_step", bus.step_cnt, 0);
        chk("mid_rst_sub", bus.sub_cnt, 0);
        chk("mid_rst_speed", bus.speed_cnt, 0);
        chk("mid_rst_valid", bus.angle_valid, 0);
        st        = 0;
        exp_speed = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_edge(0, 100);
        do_edge(0, 100);
        chk("post_rst_step", bus.step_cnt, 0);
        chk("post_rst_speed", bus.speed_cnt, exp_speed);

        repeat (5) @(posedge clk);
        chk("exp_left", exp_q.size(), 0);
        chk("err_left", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
